// File: rtl/mem_bus_pkg.sv
// Shared types and default region map for the memory bus bridge.
// Regions: user code, user data, kernel code, kernel data, boot ROM.
package mem_bus_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WRITE,
        READ_WAIT,
        READ_CAP,
        ERR
    } bridgeState_t;

    localparam int unsigned REGION_IDX_W = 3;
    localparam int unsigned LAT_CNT_W    = 2;

    localparam int unsigned REGION_USER_CODE   = 0;
    localparam int unsigned REGION_USER_DATA   = 1;
    localparam int unsigned REGION_KERNEL_CODE = 2;
    localparam int unsigned REGION_KERNEL_DATA = 3;
    localparam int unsigned REGION_BOOT        = 4;

    // Region i occupies bits [i*32 +: 32]; region 0 is the rightmost word.
    localparam logic [5*32-1:0] MEM_MAP_BASE_DEFAULT = {
        32'hBFC0_0000, 32'h9000_0000, 32'h8000_0000, 32'h1001_0000, 32'h0040_0000
    };
    localparam logic [5*32-1:0] MEM_MAP_LIMIT_DEFAULT = {
        32'hBFC0_01FF, 32'h9000_0FFF, 32'h8000_1FFF, 32'h1001_1FFF, 32'h0040_3FFF
    };

endpackage

// File: rtl/mem_bus_if.sv
// Bus bundle between the core master/RAM regions and the bridge.
// Port-style names are kept so existing wiring maps one-to-one.
interface mem_bus_if #(
    parameter int unsigned NUM_REGIONS = 5,
    parameter int unsigned ADDR_W      = 32,
    parameter int unsigned DATA_W      = 32
);
    logic                          iReq;
    logic                          iWe;
    logic [DATA_W/8-1:0]           iBe;
    logic [ADDR_W-1:0]             iAddr;
    logic [DATA_W-1:0]             iWData;
    logic                          oReady;
    logic                          oAck;
    logic                          oErr;
    logic [DATA_W-1:0]             oRData;
    logic [ADDR_W-1:0]             oMemAddr;
    logic [DATA_W/8-1:0]           oMemBe;
    logic [DATA_W-1:0]             oMemWData;
    logic [NUM_REGIONS-1:0]        oMemWren;
    logic [NUM_REGIONS*DATA_W-1:0] iMemRData;

    modport master (
        output iReq, iWe, iBe, iAddr, iWData, iMemRData,
        input  oReady, oAck, oErr, oRData, oMemAddr, oMemBe, oMemWData, oMemWren
    );

    modport slave (
        input  iReq, iWe, iBe, iAddr, iWData, iMemRData,
        output oReady, oAck, oErr, oRData, oMemAddr, oMemBe, oMemWData, oMemWren
    );
endinterface

// File: rtl/mem_region_decode.sv
// Combinational address decoder: reports whether an address falls in a
// mapped region and which one; on overlap the lowest index wins.
module mem_region_decode
    import mem_bus_pkg::*;
#(
    parameter int unsigned                NUM_REGIONS  = 5,
    parameter int unsigned                ADDR_W       = 32,
    parameter logic [NUM_REGIONS*ADDR_W-1:0] REGION_BASE  = MEM_MAP_BASE_DEFAULT,
    parameter logic [NUM_REGIONS*ADDR_W-1:0] REGION_LIMIT = MEM_MAP_LIMIT_DEFAULT
) (
    input  logic [ADDR_W-1:0]       addr,
    output logic                    hit,
    output logic [REGION_IDX_W-1:0] idx
);

    always_comb begin
        hit = 1'b0;
        idx = '0;
        for (int unsigned i = 0; i < NUM_REGIONS; i++) begin
            if (!hit &&
                addr >= REGION_BASE[i*ADDR_W +: ADDR_W] &&
                addr <= REGION_LIMIT[i*ADDR_W +: ADDR_W]) begin
                hit = 1'b1;
                idx = REGION_IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/mem_bus_bridge.sv
// Registered bridge from the core memory bus to N synchronous RAM regions.
// Optional MEM_BUS_ERR_CAPTURE_EN adds a sticky first-error address capture.
module mem_bus_bridge
    import mem_bus_pkg::*;
#(
    parameter int unsigned                   NUM_REGIONS  = 5,
    parameter int unsigned                   ADDR_W       = 32,
    parameter int unsigned                   DATA_W       = 32,
    parameter int unsigned                   RD_LAT       = 1,
    parameter logic [NUM_REGIONS*ADDR_W-1:0] REGION_BASE  = MEM_MAP_BASE_DEFAULT,
    parameter logic [NUM_REGIONS*ADDR_W-1:0] REGION_LIMIT = MEM_MAP_LIMIT_DEFAULT,
    parameter logic [NUM_REGIONS-1:0]        REGION_RO    = 5'b10000
) (
    input  logic         iCLK,
    input  logic         iRST_n,
    mem_bus_if.slave     bus
`ifdef MEM_BUS_ERR_CAPTURE_EN
    ,
    output logic [ADDR_W-1:0] oErrAddr,
    output logic              oErrValid,
    input  logic              iErrClr
`endif
);

    bridgeState_t            state, nextState;
    logic [REGION_IDX_W-1:0] hitIdxR;
    logic [LAT_CNT_W-1:0]    latCnt;
    logic [DATA_W-1:0]       rDataR;
    logic                    readAckR;
    logic [ADDR_W-1:0]       memAddrR;
    logic [DATA_W/8-1:0]     memBeR;
    logic [DATA_W-1:0]       memWDataR;

    logic                    decHit;
    logic [REGION_IDX_W-1:0] decIdx;
    logic [7:0]              roMask;
    logic                    accept;
    logic                    reqErr;
    logic [DATA_W-1:0]       selRData;

    mem_region_decode #(
        .NUM_REGIONS (NUM_REGIONS),
        .ADDR_W      (ADDR_W),
        .REGION_BASE (REGION_BASE),
        .REGION_LIMIT(REGION_LIMIT)
    ) uDecode (
        .addr(bus.iAddr),
        .hit (decHit),
        .idx (decIdx)
    );

    assign roMask = 8'(REGION_RO);
    assign accept = (state == IDLE) && bus.iReq;
    assign reqErr = !decHit || (bus.iWe && roMask[decIdx]);

    always_comb begin
        nextState = state;
        unique case (state)
            IDLE: begin
                if (bus.iReq) begin
                    if (reqErr)      nextState = ERR;
                    else if (bus.iWe) nextState = WRITE;
                    else             nextState = READ_WAIT;
                end
            end
            WRITE:     nextState = IDLE;
            READ_WAIT: if (latCnt == '0) nextState = READ_CAP;
            READ_CAP:  nextState = IDLE;
            ERR:       nextState = IDLE;
            default:   nextState = IDLE;
        endcase
    end

    always_ff @(posedge iCLK or negedge iRST_n) begin
        if (!iRST_n) begin
            state     <= IDLE;
            hitIdxR   <= '0;
            latCnt    <= '0;
            rDataR    <= '0;
            readAckR  <= 1'b0;
            memAddrR  <= '0;
            memBeR    <= '0;
            memWDataR <= '0;
        end else begin
            state    <= nextState;
            readAckR <= (state == READ_CAP);
            if (accept) begin
                memAddrR  <= bus.iAddr;
                memBeR    <= bus.iBe;
                memWDataR <= bus.iWData;
                hitIdxR   <= decIdx;
                latCnt    <= LAT_CNT_W'(RD_LAT - 1);
            end else if (state == READ_WAIT && latCnt != '0) begin
                latCnt <= latCnt - 1'b1;
            end
            if (state == READ_CAP) rDataR <= selRData;
        end
    end

    // Explicit mux keeps the region select in range for any NUM_REGIONS.
    always_comb begin
        selRData = '0;
        for (int unsigned i = 0; i < NUM_REGIONS; i++) begin
            if (hitIdxR == REGION_IDX_W'(i)) selRData = bus.iMemRData[i*DATA_W +: DATA_W];
        end
    end

    // Strobe decoded from the state register so an async reset drops it at once.
    always_comb begin
        bus.oMemWren = '0;
        for (int unsigned i = 0; i < NUM_REGIONS; i++) begin
            bus.oMemWren[i] = (state == WRITE) && (hitIdxR == REGION_IDX_W'(i));
        end
    end

    assign bus.oReady    = (state == IDLE);
    assign bus.oAck      = (state == WRITE) || (state == ERR) || readAckR;
    assign bus.oErr      = (state == ERR);
    assign bus.oRData    = (state == ERR) ? '0 : rDataR;
    assign bus.oMemAddr  = memAddrR;
    assign bus.oMemBe    = memBeR;
    assign bus.oMemWData = memWDataR;

`ifdef MEM_BUS_ERR_CAPTURE_EN
    // A new error wins over a simultaneous clear.
    always_ff @(posedge iCLK or negedge iRST_n) begin
        if (!iRST_n) begin
            oErrAddr  <= '0;
            oErrValid <= 1'b0;
        end else if (accept && reqErr && (!oErrValid || iErrClr)) begin
            oErrAddr  <= bus.iAddr;
            oErrValid <= 1'b1;
        end else if (iErrClr) begin
            oErrValid <= 1'b0;
        end
    end
`endif

endmodule

// File: tb/tb_mem_bus_bridge.sv
// Bench for mem_bus_bridge: two instances (RD_LAT 1 and 3) checked against
// a transaction-level model every cycle, plus directed literal checks.
`timescale 1ns/1ps
module tb_mem_bus_bridge;

    localparam int NR = 5;
    localparam int AW = 32;
    localparam int DW = 32;

    localparam logic [31:0] BASE  [5] = '{32'h0040_0000, 32'h1001_0000, 32'h8000_0000, 32'h9000_0000, 32'hBFC0_0000};
    localparam logic [31:0] LIMIT [5] = '{32'h0040_3FFF, 32'h1001_1FFF, 32'h8000_1FFF, 32'h9000_0FFF, 32'hBFC0_01FF};
    localparam int          LAT   [2] = '{1, 3};

    logic clk = 1'b0;
    logic rstN = 1'b0;
    always #5 clk = ~clk;

    logic        req   [2];
    logic        we    [2];
    logic [3:0]  be    [2];
    logic [31:0] addr  [2];
    logic [31:0] wdata [2];
    logic [159:0] ramData;

    logic        ready [2];
    logic        ack   [2];
    logic        err   [2];
    logic [31:0] rdata [2];
    logic [31:0] mAddr [2];
    logic [3:0]  mBe   [2];
    logic [31:0] mWData[2];
    logic [4:0]  wren  [2];

    mem_bus_if #(.NUM_REGIONS(NR), .ADDR_W(AW), .DATA_W(DW)) busA ();
    mem_bus_if #(.NUM_REGIONS(NR), .ADDR_W(AW), .DATA_W(DW)) busB ();

    assign busA.iReq = req[0];   assign busB.iReq = req[1];
    assign busA.iWe = we[0];     assign busB.iWe = we[1];
    assign busA.iBe = be[0];     assign busB.iBe = be[1];
    assign busA.iAddr = addr[0]; assign busB.iAddr = addr[1];
    assign busA.iWData = wdata[0]; assign busB.iWData = wdata[1];
    assign busA.iMemRData = ramData; assign busB.iMemRData = ramData;

    assign ready[0] = busA.oReady;     assign ready[1] = busB.oReady;
    assign ack[0] = busA.oAck;         assign ack[1] = busB.oAck;
    assign err[0] = busA.oErr;         assign err[1] = busB.oErr;
    assign rdata[0] = busA.oRData;     assign rdata[1] = busB.oRData;
    assign mAddr[0] = busA.oMemAddr;   assign mAddr[1] = busB.oMemAddr;
    assign mBe[0] = busA.oMemBe;       assign mBe[1] = busB.oMemBe;
    assign mWData[0] = busA.oMemWData; assign mWData[1] = busB.oMemWData;
    assign wren[0] = busA.oMemWren;    assign wren[1] = busB.oMemWren;

`ifdef MEM_BUS_ERR_CAPTURE_EN
    logic [31:0] errAddrA, errAddrB;
    logic        errValidA, errValidB;
    logic        errClr;
`endif

    mem_bus_bridge #(.NUM_REGIONS(NR), .ADDR_W(AW), .DATA_W(DW), .RD_LAT(1)) dutA (
        .iCLK(clk), .iRST_n(rstN), .bus(busA)
`ifdef MEM_BUS_ERR_CAPTURE_EN
        , .oErrAddr(errAddrA), .oErrValid(errValidA), .iErrClr(errClr)
`endif
    );

    mem_bus_bridge #(.NUM_REGIONS(NR), .ADDR_W(AW), .DATA_W(DW), .RD_LAT(3)) dutB (
        .iCLK(clk), .iRST_n(rstN), .bus(busB)
`ifdef MEM_BUS_ERR_CAPTURE_EN
        , .oErrAddr(errAddrB), .oErrValid(errValidB), .iErrClr(1'b0)
`endif
    );

    int nChecks = 0;
    int nFail   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int regionOf(input logic [31:0] a);
        for (int i = 0; i < 5; i++) begin
            if (a >= BASE[i] && a <= LIMIT[i]) return i;
        end
        return -1;
    endfunction

    // Transaction model: each accepted request schedules its completion cycle.
    int          cyc = 0;
    int          readyFrom [2];
    int          ackAt     [2];
    bit          ackErr    [2];
    bit          ackRead   [2];
    int          rdRegion  [2];
    int          wrenAt    [2];
    logic [4:0]  wrenVal   [2];
    logic [31:0] expRD     [2];
    logic [31:0] expAddr   [2];
    logic [3:0]  expBe     [2];
    logic [31:0] expWData  [2];

    always @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            for (int d = 0; d < 2; d++) begin
                readyFrom[d] = 0;  ackAt[d] = -1; ackErr[d] = 0; ackRead[d] = 0;
                rdRegion[d] = 0;   wrenAt[d] = -1; wrenVal[d] = '0; expRD[d] = '0;
                expAddr[d] = '0;   expBe[d] = '0;  expWData[d] = '0;
            end
        end else begin
            for (int d = 0; d < 2; d++) begin
                if (ackRead[d] && ackAt[d] == cyc + 1)
                    expRD[d] = ramData[rdRegion[d]*32 +: 32];
                if (req[d] && cyc >= readyFrom[d]) begin
                    int r;
                    r = regionOf(addr[d]);
                    expAddr[d] = addr[d]; expBe[d] = be[d]; expWData[d] = wdata[d];
                    if (r < 0 || (we[d] && r == 4)) begin
                        ackAt[d] = cyc + 1; ackErr[d] = 1; ackRead[d] = 0;
                        readyFrom[d] = cyc + 2;
                    end else if (we[d]) begin
                        ackAt[d] = cyc + 1; ackErr[d] = 0; ackRead[d] = 0;
                        wrenAt[d] = cyc + 1; wrenVal[d] = 5'(1 << r);
                        readyFrom[d] = cyc + 2;
                    end else begin
                        ackAt[d] = cyc + 2 + LAT[d]; ackErr[d] = 0; ackRead[d] = 1;
                        rdRegion[d] = r;
                        readyFrom[d] = cyc + 2 + LAT[d];
                    end
                end
            end
            cyc = cyc + 1;
        end
    end

    int          ackCnt   [2] = '{0, 0};
    int          wrenCnt  [2] = '{0, 0};
    int          lastAck  [2] = '{-1, -1};
    logic        lastErr  [2];
    logic [31:0] lastRD   [2];
    logic [4:0]  lastWren [2];

    always @(negedge clk) begin
        if (rstN) begin
            for (int d = 0; d < 2; d++) begin
                bit ea, ee;
                ea = (cyc == ackAt[d]);
                ee = ea && ackErr[d];
                chk($sformatf("ready[%0d]", d), ready[d], cyc >= readyFrom[d]);
                chk($sformatf("ack[%0d]", d), ack[d], ea);
                chk($sformatf("err[%0d]", d), err[d], ee);
                chk($sformatf("wren[%0d]", d), wren[d], (cyc == wrenAt[d]) ? wrenVal[d] : 5'b0);
                chk($sformatf("rdata[%0d]", d), rdata[d], ee ? 32'h0 : expRD[d]);
                chk($sformatf("memAddr[%0d]", d), mAddr[d], expAddr[d]);
                chk($sformatf("memBe[%0d]", d), mBe[d], expBe[d]);
                chk($sformatf("memWData[%0d]", d), mWData[d], expWData[d]);
                if (ack[d]) begin
                    ackCnt[d]++; lastAck[d] = cyc; lastErr[d] = err[d]; lastRD[d] = rdata[d];
                end
                if (wren[d] != 5'b0) begin
                    wrenCnt[d]++; lastWren[d] = wren[d];
                end
            end
        end
    end

    task automatic issue(input int d, input logic w, input logic [3:0] b,
                         input logic [31:0] a, input logic [31:0] wd, output int acc);
        int n = 0;
        while (!ready[d] && n < 50) begin @(negedge clk); #1; n++; end
        if (!ready[d]) chk($sformatf("readyTimeout[%0d]", d), 0, 1);
        req[d] = 1'b1; we[d] = w; be[d] = b; addr[d] = a; wdata[d] = wd;
        acc = cyc;
        @(negedge clk); #1;
        req[d] = 1'b0;
    endtask

    task automatic waitIdle(input int d);
        int n = 0;
        do begin @(negedge clk); #1; n++; end while (!ready[d] && n < 50);
        if (!ready[d]) chk($sformatf("idleTimeout[%0d]", d), 0, 1);
    endtask

    int acc, accB, a0, w0;

    initial begin
        for (int d = 0; d < 2; d++) begin
            req[d] = 0; we[d] = 0; be[d] = '0; addr[d] = '0; wdata[d] = '0;
        end
        ramData = '0;
`ifdef MEM_BUS_ERR_CAPTURE_EN
        errClr = 1'b0;
`endif
        repeat (2) @(negedge clk);
        #1;
        chk("rst ready", ready[0], 1'b1);
        chk("rst ack", ack[0], 1'b0);
        chk("rst rdata", rdata[0], 32'h0);
        chk("rst wren", wren[0], 5'b0);
        chk("rst memAddr", mAddr[1], 32'h0);
        @(negedge clk);
        rstN = 1'b1;
        @(negedge clk); #1;

        // Write to user data.
        w0 = wrenCnt[0];
        issue(0, 1'b1, 4'hF, 32'h1001_0004, 32'hDEAD_BEEF, acc);
        waitIdle(0);
        chk("wr strobes", wrenCnt[0] - w0, 1);
        chk("wr strobe val", lastWren[0], 5'b00010);
        chk("wr ack lat", lastAck[0] - acc, 1);
        chk("wr err", lastErr[0], 1'b0);

        // Reads from user code at both latencies.
        ramData = {32'hB007_0004, 32'hCAFE_0003, 32'h0BAD_0002, 32'h5555_0001, 32'h1234_5678};
        issue(0, 1'b0, 4'hF, 32'h0040_0000, 32'h0, acc);
        waitIdle(0);
        chk("rdA data", lastRD[0], 32'h1234_5678);
        chk("rdA ack lat", lastAck[0] - acc, 3);
        issue(1, 1'b0, 4'hF, 32'h0040_0000, 32'h0, acc);
        waitIdle(1);
        chk("rdB data", lastRD[1], 32'h1234_5678);
        chk("rdB ack lat", lastAck[1] - acc, 5);

        // Unmapped read and read-only write.
        w0 = wrenCnt[0];
        issue(0, 1'b0, 4'hF, 32'h2000_0000, 32'h0, acc);
        waitIdle(0);
        chk("unmapped ack lat", lastAck[0] - acc, 1);
        chk("unmapped err", lastErr[0], 1'b1);
        chk("unmapped rdata", lastRD[0], 32'h0);
`ifdef MEM_BUS_ERR_CAPTURE_EN
        chk("errAddr", errAddrA, 32'h2000_0000);
        chk("errValid", errValidA, 1'b1);
`endif
        issue(0, 1'b1, 4'hF, 32'hBFC0_0000, 32'h1111_2222, acc);
        waitIdle(0);
        chk("ro err", lastErr[0], 1'b1);
        chk("ro no strobe", wrenCnt[0] - w0, 0);
`ifdef MEM_BUS_ERR_CAPTURE_EN
        chk("errAddr sticky", errAddrA, 32'h2000_0000);
        @(negedge clk); #1; errClr = 1'b1;
        @(negedge clk); #1; errClr = 1'b0;
        chk("errValid cleared", errValidA, 1'b0);
`endif

        // Boundary and per-region accesses, checked by the model.
        issue(0, 1'b1, 4'b0011, 32'h9000_0FFC, 32'hA5A5_5A5A, acc); waitIdle(0);
        chk("kdata strobe", lastWren[0], 5'b01000);
        issue(0, 1'b0, 4'hF, 32'h8000_1FFC, 32'h0, acc); waitIdle(0);
        chk("kcode data", lastRD[0], 32'h0BAD_0002);
        issue(0, 1'b0, 4'hF, 32'h0040_4000, 32'h0, acc); waitIdle(0);
        chk("past limit err", lastErr[0], 1'b1);
        issue(0, 1'b0, 4'hF, 32'hBFC0_01FC, 32'h0, acc); waitIdle(0);
        chk("boot read", lastRD[0], 32'hB007_0004);
        issue(1, 1'b0, 4'hF, 32'h9000_0000, 32'h0, acc); waitIdle(1);
        chk("kdataB read", lastRD[1], 32'hCAFE_0003);

        // iReq held through a read: one access, then a back-to-back accept in the ack cycle.
        a0 = ackCnt[0];
        while (!ready[0]) begin @(negedge clk); #1; end
        req[0] = 1'b1; we[0] = 1'b0; be[0] = 4'hF; addr[0] = 32'h1001_0000;
        repeat (4) begin @(negedge clk); #1; end
        req[0] = 1'b0;
        waitIdle(0);
        chk("held acks", ackCnt[0] - a0, 2);
        chk("held data", lastRD[0], 32'h5555_0001);

        // Reset while B waits on RAM and A drives a strobe.
        issue(1, 1'b0, 4'hF, 32'h1001_0010, 32'h0, accB);
        issue(0, 1'b1, 4'hF, 32'h0040_0010, 32'h7777_8888, acc);
        chk("strobe before rst", wren[0], 5'b00001);
        rstN = 1'b0;
        #1;
        chk("rst wren drop", wren[0], 5'b0);
        chk("rst ack A", ack[0], 1'b0);
        chk("rst ready B", ready[1], 1'b1);
        chk("rst rdata B", rdata[1], 32'h0);
        chk("rst memAddr B", mAddr[1], 32'h0);
        repeat (2) @(negedge clk);
        rstN = 1'b1;
        a0 = ackCnt[1];
        repeat (8) begin @(negedge clk); #1; end
        chk("no ack after rst", ackCnt[1] - a0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

endmodule
